// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul command fetcher: MMIO map, flag codes,
// FSM states, the captured command record and the command validation rules.
package matmul_pkg;

   // Captured words are held at this width so the validation helpers can be
   // shared by every instance; DATA_WIDTH of an instance must not exceed it.
   localparam int CMD_W = 64;

   // MMIO offsets of the host-visible registers
   localparam logic [11:0] OFS_A_IN  = 12'h000;
   localparam logic [11:0] OFS_B_IN  = 12'h100;
   localparam logic [11:0] OFS_C_OUT = 12'h200;
   localparam logic [11:0] OFS_DIM_M = 12'h600;
   localparam logic [11:0] OFS_DIM_N = 12'h700;
   localparam logic [11:0] OFS_DIM_P = 12'h800;
   localparam logic [11:0] OFS_FLAG  = 12'hA00;
   localparam logic [11:0] OFS_BIAS  = 12'hD00;

   // MATMUL_Flag codes
   localparam logic [1:0] FLAG_IDLE  = 2'd0;
   localparam logic [1:0] FLAG_START = 2'd1;
   localparam logic [1:0] FLAG_DONE  = 2'd2;
   localparam logic [1:0] FLAG_ERR   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_POLL, S_POLL_CHK, S_FETCH, S_CHECK, S_ISSUE, S_WAIT, S_WB
   } state_t;

   typedef struct packed {
      logic [CMD_W-1:0] a_addr;
      logic [CMD_W-1:0] b_addr;
      logic [CMD_W-1:0] c_addr;
      logic [CMD_W-1:0] bias_addr;
      logic [CMD_W-1:0] m;
      logic [CMD_W-1:0] n;
      logic [CMD_W-1:0] p;
      logic             bias_en;
   } matmul_cmd_t;

   // Register read order during FETCH: A, B, C, M, N, P, Bias
   function automatic logic [11:0] fetch_offset(input logic [2:0] idx);
      case (idx)
         3'd0:    return OFS_A_IN;
         3'd1:    return OFS_B_IN;
         3'd2:    return OFS_C_OUT;
         3'd3:    return OFS_DIM_M;
         3'd4:    return OFS_DIM_N;
         3'd5:    return OFS_DIM_P;
         3'd6:    return OFS_BIAS;
         default: return 12'h000;
      endcase
   endfunction

   // An operand address must fit the port and point above the 4 KiB MMIO window
   function automatic logic addr_in_sram(input logic [CMD_W-1:0] v,
                                         input int data_w, input int addr_w);
      logic too_wide;
      logic above_mmio;
      too_wide   = 1'b0;
      above_mmio = 1'b0;
      for (int i = 0; i < CMD_W; i++) begin
         if (i >= addr_w && i < data_w && v[i]) too_wide = 1'b1;
         if (i >= 12 && i < addr_w && v[i])     above_mmio = 1'b1;
      end
      return !too_wide && above_mmio;
   endfunction

   function automatic logic dim_ok(input logic [CMD_W-1:0] v, input int max_dim);
      return (v != '0) && (v <= CMD_W'(max_dim));
   endfunction

   function automatic logic cmd_is_valid(input matmul_cmd_t c, input int data_w,
                                         input int addr_w, input int max_dim);
      return dim_ok(c.m, max_dim) && dim_ok(c.n, max_dim) && dim_ok(c.p, max_dim) &&
             addr_in_sram(c.a_addr, data_w, addr_w) &&
             addr_in_sram(c.b_addr, data_w, addr_w) &&
             addr_in_sram(c.c_addr, data_w, addr_w) &&
             ((c.bias_addr == '0) || addr_in_sram(c.bias_addr, data_w, addr_w));
   endfunction

endpackage

// File: rtl/matmul_cmd_fetch.sv
// Polls MATMUL_Flag, fetches and validates one matmul job from the MMIO map,
// hands it to the engine and writes DONE/ERR back to the flag.
module matmul_cmd_fetch
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 16,
   parameter int MAX_DIM       = 64,
   parameter int POLL_INTERVAL = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_q,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [ADDR_WIDTH-1:0] cmd_a_addr,
   output logic [ADDR_WIDTH-1:0] cmd_b_addr,
   output logic [ADDR_WIDTH-1:0] cmd_c_addr,
   output logic [ADDR_WIDTH-1:0] cmd_bias_addr,
   output logic                  cmd_bias_en,
   output logic [DATA_WIDTH-1:0] cmd_m,
   output logic [DATA_WIDTH-1:0] cmd_n,
   output logic [DATA_WIDTH-1:0] cmd_p,
   input  logic                  eng_done,
   input  logic                  eng_err,
   output logic                  busy
);

   localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_INTERVAL - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [1:0]       code_q, code_d;
   matmul_cmd_t      cmd_q;

   // State, poll counter, fetch index and write-back code registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         code_q  <= FLAG_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
      end
   end

   // Capture read data one cycle after each FETCH address (index i lands at i+1)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the captured command is reset too, so the cmd_* outputs are a
         // defined 0 out of reset rather than X until the first fetch.
         cmd_q <= '0;
      end else if (state_q == S_FETCH) begin
         case (idx_q)
            3'd1: cmd_q.a_addr <= CMD_W'(mem_q);
            3'd2: cmd_q.b_addr <= CMD_W'(mem_q);
            3'd3: cmd_q.c_addr <= CMD_W'(mem_q);
            3'd4: cmd_q.m      <= CMD_W'(mem_q);
            3'd5: cmd_q.n      <= CMD_W'(mem_q);
            3'd6: cmd_q.p      <= CMD_W'(mem_q);
            3'd7: begin
               cmd_q.bias_addr <= CMD_W'(mem_q);
               cmd_q.bias_en   <= (mem_q != '0);
            end
            default: ;
         endcase
      end
   end

   // Next-state logic and the combinational memory-port / command strobes
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      code_d    = code_q;
      mem_addr  = '0;
      mem_data  = '0;
      mem_we    = 1'b0;
      cmd_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_POLL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_POLL: begin
            mem_addr = ADDR_WIDTH'(OFS_FLAG);
            state_d  = S_POLL_CHK;
         end
         S_POLL_CHK: begin
            if (mem_q == DATA_WIDTH'(FLAG_START)) begin
               idx_d   = '0;
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            // fetch_offset returns 0 for index 7, the capture-only cycle
            mem_addr = ADDR_WIDTH'(fetch_offset(idx_q));
            if (idx_q == 3'd7) state_d = S_CHECK;
            else               idx_d   = idx_q + 3'd1;
         end
         S_CHECK: begin
            if (cmd_is_valid(cmd_q, DATA_WIDTH, ADDR_WIDTH, MAX_DIM)) begin
               state_d = S_ISSUE;
            end else begin
               code_d  = FLAG_ERR;
               state_d = S_WB;
            end
         end
         S_ISSUE: begin
            cmd_valid = 1'b1;
            if (cmd_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (eng_done) begin
               code_d  = eng_err ? FLAG_ERR : FLAG_DONE;
               state_d = S_WB;
            end
         end
         S_WB: begin
            mem_addr = ADDR_WIDTH'(OFS_FLAG);
            mem_data = DATA_WIDTH'(code_q);
            mem_we   = 1'b1;
            cnt_d    = '0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Command fields come straight from the captured (validated) words
   assign cmd_a_addr    = cmd_q.a_addr[ADDR_WIDTH-1:0];
   assign cmd_b_addr    = cmd_q.b_addr[ADDR_WIDTH-1:0];
   assign cmd_c_addr    = cmd_q.c_addr[ADDR_WIDTH-1:0];
   assign cmd_bias_addr = cmd_q.bias_addr[ADDR_WIDTH-1:0];
   assign cmd_bias_en   = cmd_q.bias_en;
   assign cmd_m         = cmd_q.m[DATA_WIDTH-1:0];
   assign cmd_n         = cmd_q.n[DATA_WIDTH-1:0];
   assign cmd_p         = cmd_q.p[DATA_WIDTH-1:0];
   assign busy          = (state_q != S_IDLE);

endmodule
